arbitro_rr8: RTL and testbench

//  Round-robin arbiter: shares one resource among 8 requesters, one-hot grant.

---
 rtl/arbitro_rr8_pkg.sv | 15 +
 rtl/arbitro_rr8_dec.sv | 15 +
 rtl/arbitro_rr8.sv | 101 ++++++++++
 tb/tb_arbitro_rr8.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_rr8_pkg.sv
// rtl/arbitro_rr8_pkg.sv - shared constants and state encoding for the 8-way round-robin arbiter
package arbitro_rr8_pkg;

    localparam int N            = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;
    localparam int HOLD_W_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/arbitro_rr8_dec.sv
// rtl/arbitro_rr8_dec.sv - combinational 3-to-8 one-hot decoder
module dec_onehot8
    import arbitro_rr8_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    // Exactly one bit set at the position named by idx
    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/arbitro_rr8.sv
// rtl/arbitro_rr8.sv - 8-requester round-robin arbiter with bounded hold time
module arbitro_rr8
    import arbitro_rr8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = HOLD_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    // Last hold count at which the grantee still owns the resource
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic [N-1:0]       winner_onehot;

    // Rotating priority search: first requester at or after ptr, wrapping modulo 8
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    dec_onehot8 u_dec (
        .idx    (winner),
        .onehot (winner_onehot)
    );

    // Arbitration FSM with registered grant, index, valid and timeout outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (|req) begin
                        state     <= GRANT;
                        gnt_idx   <= winner;
                        gnt       <= winner_onehot;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    // Voluntary release wins over the forced one in the same cycle
                    if (done || !req[gnt_idx]) begin
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= RELEASE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                    end
                end
                RELEASE: begin
                    // Next search starts just past the previous grantee
                    ptr     <= gnt_idx + 1'b1;
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                    timeout   <= 1'b0;
                    hold_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_rr8.sv
// tb/tb_arbitro_rr8.sv - self-checking bench for arbitro_rr8
module tb_arbitro_rr8;

    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    arbitro_rr8 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 owned, 2 turnaround; age = cycles owned so far
    int m_phase, m_owner, m_age, m_next, m_to;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0; m_owner <= 0; m_age <= 0; m_next <= 0; m_to <= 0;
        end else begin
            case (m_phase)
                0: begin
                    m_to <= 0;
                    if (req != 8'h00) begin
                        m_owner <= pick(req, m_next);
                        m_phase <= 1;
                        m_age   <= 1;
                    end
                end
                1: begin
                    if (done || !req[m_owner]) m_phase <= 2;
                    else if (m_age == MAXH) begin m_phase <= 2; m_to <= 1; end
                    else m_age <= m_age + 1;
                end
                default: begin
                    m_next  <= (m_owner + 1) % 8;
                    m_phase <= 0;
                    m_to    <= 0;
                end
            endcase
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        check("gnt", gnt, (m_phase == 1) ? (1 << m_owner) : 0);
        check("gnt_valid", gnt_valid, (m_phase == 1) ? 1 : 0);
        check("timeout", timeout, m_to);
        if (m_phase == 1) check("gnt_idx", gnt_idx, m_owner);
    end

    int zeros;

    task automatic wait_gnt(input logic [7:0] exp, input string nm);
        zeros = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (gnt != 8'h00) break;
            zeros++;
        end
        check(nm, gnt, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 8'h00; done = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cnt;

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_valid", gnt_valid, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;

        // Rotation and wrap with done held
        @(negedge clk);
        req = 8'hFF; done = 1'b1;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] e;
            e = 8'h01 << (i % 8);
            wait_gnt(e, "rotate");
            if (i > 0) check("rotate_gap", zeros, 2);
        end

        // Pointer skip: after idx 5, req=09 scans 6,7,0 -> idx 0 then idx 3
        do_reset();
        req = 8'hFF; done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] e;
            e = 8'h01 << i;
            wait_gnt(e, "skip_pre");
        end
        req = 8'h09;
        wait_gnt(8'h01, "skip_first");
        wait_gnt(8'h08, "skip_second");

        // Timeout at MAX_HOLD
        do_reset();
        req = 8'h04;
        wait_gnt(8'h04, "to_grant");
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt == 8'h04) cnt++;
            else break;
        end
        check("to_len", cnt, 16);
        check("to_pulse", timeout, 1);
        check("to_gnt_off", gnt, 0);
        req = 8'h0C;
        wait_gnt(8'h08, "to_ptr3");
        done = 1'b1;
        @(negedge clk);
        done = 1'b0; req = 8'h00;

        // done on the 16th grant cycle suppresses timeout
        do_reset();
        req = 8'h04;
        wait_gnt(8'h04, "dn16_grant");
        for (int i = 1; i < 16; i++) @(negedge clk);
        check("dn16_still", gnt, 8'h04);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("dn16_gnt", gnt, 0);
        check("dn16_timeout", timeout, 0);

        // Withdrawal mid-grant
        do_reset();
        req = 8'h02;
        wait_gnt(8'h02, "wd_grant");
        repeat (2) @(negedge clk);
        req = 8'h00;
        @(negedge clk);
        check("wd_gnt", gnt, 0);

        // Single requester, done on 3rd grant cycle
        do_reset();
        req = 8'h01;
        wait_gnt(8'h01, "single");
        repeat (2) @(negedge clk);
        check("single_c3", gnt, 8'h01);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        check("single_off", gnt, 0);
        wait_gnt(8'h01, "single_again");
        check("single_gap", zeros + 1, 2);
        req = 8'h00;

        // Async reset mid-grant, then fresh arbitration from ptr 0
        do_reset();
        req = 8'h10;
        wait_gnt(8'h10, "ar_grant");
        #2 rst = 1'b1;
        #1;
        check("ar_gnt", gnt, 0);
        check("ar_valid", gnt_valid, 0);
        @(negedge clk);
        rst = 1'b0; req = 8'hFF; done = 1'b1;
        wait_gnt(8'h01, "ar_first");
        req = 8'h00; done = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
